// File: rtl/huff_bit_packer.sv
// huff_bit_packer: packs serial Huffman code bits MSB-first into bytes and buffers them in a FIFO
module huff_bit_packer #(
    parameter int DEPTH = 8
) (
    input  logic        Clk_in,
    input  logic        n_Rst,
    input  logic        Bit_in,
    input  logic        Bit_vld,
    input  logic        Fin_in,
    input  logic        Byte_rdy,
    output logic [7:0]  Byte_out,
    output logic        Byte_vld,
    output logic [15:0] Bit_cnt,
    output logic [2:0]  Pad_cnt,
    output logic        Overflow,
    output logic        Done
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {PACK, FLUSH, DRAIN, DONE} state_t;

    state_t          state, state_nxt;
    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic [7:0]      sr;
    logic [2:0]      k;
    logic            fin_q;
    logic            accept, push, pop, full, wr_en, drop;
    logic [7:0]      push_data;

    assign Byte_vld = count != '0;
    assign Byte_out = Byte_vld ? mem[rd_ptr] : 8'h00;
    assign Done     = state == DONE;
    assign full     = count == CW'(DEPTH);
    assign pop      = Byte_vld && Byte_rdy;

    // state register
    always_ff @(posedge Clk_in or negedge n_Rst)
        if (!n_Rst) state <= PACK;
        else        state <= state_nxt;

    // next state plus bit-accept and byte-push decisions
    always_comb begin
        state_nxt = state;
        accept    = state == PACK && Bit_vld;
        push      = (accept && k == 3'd7) || (state == FLUSH && k != 3'd0);
        push_data = state == FLUSH ? sr << (4'd8 - {1'b0, k}) : {sr[6:0], Bit_in};
        wr_en     = push && (!full || pop);
        drop      = push && full && !pop;
        case (state)
            PACK:    state_nxt = (Fin_in && !fin_q) ? FLUSH : PACK;
            FLUSH:   state_nxt = DRAIN;
            DRAIN:   state_nxt = Byte_vld ? DRAIN : DONE;
            default: state_nxt = DONE;
        endcase
    end

    // shift register, counters, status flags and FIFO pointers
    always_ff @(posedge Clk_in or negedge n_Rst)
        if (!n_Rst) begin
            sr       <= '0;
            k        <= '0;
            fin_q    <= 1'b0;
            Bit_cnt  <= '0;
            Pad_cnt  <= '0;
            Overflow <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            fin_q <= Fin_in;
            if (accept) begin
                sr <= {sr[6:0], Bit_in};
                k  <= k + 3'd1;
                if (Bit_cnt != 16'hFFFF) Bit_cnt <= Bit_cnt + 16'd1;
            end
            if (state == FLUSH) begin
                Pad_cnt <= 3'd0 - k;
                k       <= '0;
            end
            if (drop) Overflow <= 1'b1;
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(wr_en) - CW'(pop);
        end

    // FIFO storage; the occupancy count alone decides what is valid
    always_ff @(posedge Clk_in)
        if (wr_en) mem[wr_ptr] <= push_data;
endmodule

// File: tb/tb_huff_bit_packer.sv
// tb_huff_bit_packer: directed and random stimulus checked against a byte-queue reference model
module tb_huff_bit_packer;
    localparam int DEPTH = 8;

    logic        Clk_in = 1'b0, n_Rst = 1'b0, Bit_in = 1'b0, Bit_vld = 1'b0, Fin_in = 1'b0, Byte_rdy = 1'b0;
    logic [7:0]  Byte_out;
    logic        Byte_vld, Overflow, Done;
    logic [15:0] Bit_cnt;
    logic [2:0]  Pad_cnt;

    int checks = 0, errors = 0;
    byte unsigned q[$];
    int pv, pn, ph, cnt, pad, n;
    bit ovf, finp;

    huff_bit_packer #(.DEPTH(DEPTH)) dut (
        .Clk_in(Clk_in), .n_Rst(n_Rst), .Bit_in(Bit_in), .Bit_vld(Bit_vld), .Fin_in(Fin_in),
        .Byte_rdy(Byte_rdy), .Byte_out(Byte_out), .Byte_vld(Byte_vld), .Bit_cnt(Bit_cnt),
        .Pad_cnt(Pad_cnt), .Overflow(Overflow), .Done(Done)
    );

    initial forever #5 Clk_in = ~Clk_in;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mreset;
        q.delete();
        pv = 0; pn = 0; ph = 0; cnt = 0; pad = 0; ovf = 0; finp = 0;
    endtask

    task automatic check_all;
        chk("byte_vld", 16'(q.size() > 0 ? 1 : 0), 16'(Byte_vld));
        chk("byte_out", 16'(Byte_out), 16'(q.size() > 0 ? q[0] : 8'h00));
        chk("bit_cnt", Bit_cnt, 16'(cnt));
        chk("pad_cnt", 16'(Pad_cnt), 16'(pad));
        chk("overflow", 16'(Overflow), 16'(ovf));
        chk("done", 16'(Done), 16'(ph == 3 ? 1 : 0));
    endtask

    // one clock: drive inputs, advance the model by the rules, compare after the edge
    task automatic step(input bit v, input bit b, input bit f, input bit r);
        int sz;
        bit pop, has;
        byte unsigned val;
        Bit_vld = v; Bit_in = b; Fin_in = f; Byte_rdy = r;
        @(posedge Clk_in);
        sz = q.size(); pop = sz > 0 && r; has = 0; val = 0;
        if (ph == 0) begin
            if (v) begin
                pv = pv * 2 + int'(b); pn++;
                if (cnt < 65535) cnt++;
                if (pn == 8) begin has = 1; val = 8'(pv); pv = 0; pn = 0; end
            end
            if (f && !finp) ph = 1;
        end else if (ph == 1) begin
            pad = pn == 0 ? 0 : 8 - pn;
            if (pn != 0) begin has = 1; val = 8'(pv << (8 - pn)); end
            pv = 0; pn = 0; ph = 2;
        end else if (ph == 2) begin
            if (sz == 0) ph = 3;
        end
        finp = f;
        if (pop) void'(q.pop_front());
        if (has) begin
            if (sz == DEPTH && !pop) ovf = 1;
            else q.push_back(val);
        end
        #1 check_all();
    endtask

    task automatic do_reset;
        Bit_vld = 0; Fin_in = 0; Byte_rdy = 0;
        n_Rst = 0;
        #1 mreset();
        check_all();
        #1 n_Rst = 1;
    endtask

    task automatic wait_done;
        for (int i = 0; i < 40 && !Done; i++) step(0, 0, Fin_in, 1);
        chk("done_reached", 16'(Done), 16'd1);
    endtask

    task automatic send_byte(input logic [7:0] v, input bit r);
        logic [7:0] t;
        t = v;
        for (int i = 7; i >= 0; i--) step(1, t[i], 0, r);
    endtask

    initial begin
        logic [10:0] pat;
        mreset();
        repeat (2) @(posedge Clk_in);
        #1 check_all();
        n_Rst = 1;

        send_byte(8'hB2, 1);
        chk("basic_byte", 16'(Byte_out), 16'hB2);
        chk("basic_cnt", Bit_cnt, 16'd8);
        step(0, 0, 0, 1);
        chk("basic_popped", 16'(Byte_vld), 16'd0);

        do_reset();
        pat = 11'b11111111101;
        for (int i = 10; i >= 0; i--) step(1, pat[i], 0, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        chk("flush_pad", 16'(Pad_cnt), 16'd5);
        chk("flush_head", 16'(Byte_out), 16'hFF);
        wait_done();

        do_reset();
        for (int i = 0; i < 72; i++) step(1, 1'($urandom), 0, 0);
        chk("ovf_set", 16'(Overflow), 16'd1);
        n = 0;
        while (Byte_vld && n < 20) begin step(0, 0, 0, 1); n++; end
        chk("ovf_drain_count", 16'(n), 16'd8);

        do_reset();
        for (int i = 0; i < 71; i++) step(1, 1'($urandom), 0, 0);
        step(1, 1'($urandom), 0, 1);
        chk("fullpp_ovf", 16'(Overflow), 16'd0);
        n = 0;
        while (Byte_vld && n < 20) begin step(0, 0, 0, 1); n++; end
        chk("fullpp_occ", 16'(n), 16'd8);

        do_reset();
        for (int i = 0; i < 7; i++) step(1, 1'($urandom), 0, 0);
        step(1, 1'($urandom), 1, 0);
        step(0, 0, 1, 0);
        chk("edge_pad", 16'(Pad_cnt), 16'd0);
        chk("edge_cnt", Bit_cnt, 16'd8);
        chk("edge_occ", 16'(Byte_vld), 16'd1);
        wait_done();

        do_reset();
        for (int i = 0; i < 27; i++) step(1, 1'($urandom), 0, 0);
        chk("mid_buffered", 16'(Byte_vld), 16'd1);
        do_reset();
        chk("mid_vld_low", 16'(Byte_vld), 16'd0);
        chk("mid_cnt_zero", Bit_cnt, 16'd0);
        send_byte(8'hA5, 0);
        chk("mid_new_byte", 16'(Byte_out), 16'hA5);

        for (int r = 0; r < 4; r++) begin
            do_reset();
            n = $urandom_range(40, 300);
            for (int i = 0; i < n; i++)
                step(1'($urandom), 1'($urandom), 0, $urandom_range(0, 3) == 0);
            for (int i = 0; i < 10; i++)
                step(1'($urandom), 1'($urandom), 1, $urandom_range(0, 1) == 0);
            wait_done();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
